// File: rtl/pc_stack_unit.sv
// Program counter with a bounded return-address stack for call/return.
// Misuse of the stack (overflow, underflow, simultaneous push/pop) latches a sticky error.
module pc_stack_unit #(
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall,
   input  logic [1:0]               addrSrc,
   input  logic                     push,
   input  logic                     pop,
   input  logic [ADDR_W-1:0]        jumpAddr,
   output logic [ADDR_W-1:0]        pc,
   output logic [ADDR_W-1:0]        topAddr,
   output logic [$clog2(DEPTH):0]   depth,
   output logic                     stackFull,
   output logic                     stackEmpty,
   output logic                     stackErr
);

   localparam int IW = $clog2(DEPTH);
   localparam int DW = IW + 1;
   localparam logic [DW-1:0] FULL_CNT = DW'(DEPTH);

   logic [ADDR_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] pc_reg, pc_next, pc_inc;
   logic [DW-1:0]     depth_reg, depth_next;
   logic              err_reg, err_next;
   logic              empty, full, do_push;
   logic [IW-1:0]     wr_idx, top_idx;

   assign pc_inc  = pc_reg + ADDR_W'(1);
   assign empty   = (depth_reg == '0);
   assign full    = (depth_reg == FULL_CNT);
   // Low bits of depth address the next free slot; at full they wrap to 0,
   // so top_idx still lands on the last entry.
   assign wr_idx  = depth_reg[IW-1:0];
   assign top_idx = wr_idx - IW'(1);
   assign topAddr = empty ? '0 : mem[top_idx];

   always_comb begin
      pc_next    = pc_reg;
      depth_next = depth_reg;
      err_next   = err_reg;
      do_push    = 1'b0;
      if (!stall) begin
         case (addrSrc)
            2'b00:   pc_next = pc_inc;
            2'b01:   pc_next = empty ? pc_inc : topAddr;
            default: pc_next = jumpAddr;
         endcase

         if (push && pop) begin
            err_next = 1'b1;
         end else if (push) begin
            if (full) begin
               err_next = 1'b1;
            end else begin
               do_push    = 1'b1;
               depth_next = depth_reg + DW'(1);
            end
         end else if (pop) begin
            if (empty) err_next = 1'b1;
            else       depth_next = depth_reg - DW'(1);
         end

         // A return or peek with nothing on the stack is misuse on its own.
         if (addrSrc == 2'b01 && empty) err_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg    <= '0;
         depth_reg <= '0;
         err_reg   <= 1'b0;
      end else begin
         pc_reg    <= pc_next;
         depth_reg <= depth_next;
         err_reg   <= err_next;
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (!rst && do_push && wr_idx == IW'(gi)) mem[gi] <= pc_inc;
         end
      end
   endgenerate

   assign pc         = pc_reg;
   assign depth      = depth_reg;
   assign stackFull  = full;
   assign stackEmpty = empty;
   assign stackErr   = err_reg;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed and randomized checks of pc_stack_unit against a queue-based model.
module tb_pc_stack_unit;

   localparam int ADDR_W = 12;
   localparam int DEPTH  = 8;
   localparam int AMOD   = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst, stall, push, pop;
   logic [1:0]        addrSrc;
   logic [ADDR_W-1:0] jumpAddr;
   logic [ADDR_W-1:0] pc, topAddr;
   logic [3:0]        depth;
   logic              stackFull, stackEmpty, stackErr;

   int n_checks = 0;
   int n_fail   = 0;
   int n_cyc    = 0;

   // Reference model state
   int m_pc  = 0;
   int m_stk[$];
   bit m_err = 0;

   pc_stack_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .stall(stall), .addrSrc(addrSrc), .push(push), .pop(pop),
      .jumpAddr(jumpAddr), .pc(pc), .topAddr(topAddr), .depth(depth),
      .stackFull(stackFull), .stackEmpty(stackEmpty), .stackErr(stackErr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model(input bit r, input bit s, input bit [1:0] a, input bit pu, input bit po, input int j);
      int  inc, top, npc;
      bit  emp, ful;
      if (r) begin
         m_pc = 0;
         m_stk.delete();
         m_err = 0;
         return;
      end
      if (s) return;
      emp = (m_stk.size() == 0);
      ful = (m_stk.size() == DEPTH);
      inc = (m_pc + 1) % AMOD;
      top = emp ? 0 : m_stk[$];
      if (a == 2'd0)      npc = inc;
      else if (a == 2'd1) npc = emp ? inc : top;
      else                npc = j;
      if (pu && po) m_err = 1;
      else if (pu) begin
         if (ful) m_err = 1;
         else     m_stk.push_back(inc);
      end else if (po) begin
         if (emp) m_err = 1;
         else     void'(m_stk.pop_back());
      end
      if (a == 2'd1 && emp) m_err = 1;
      m_pc = npc;
   endtask

   task automatic cyc(input bit r, input bit s, input bit [1:0] a, input bit pu, input bit po, input int j);
      int exp_top;
      rst = r; stall = s; addrSrc = a; push = pu; pop = po; jumpAddr = ADDR_W'(j);
      model(r, s, a, pu, po, j);
      @(posedge clk);
      #1;
      n_cyc++;
      exp_top = (m_stk.size() == 0) ? 0 : m_stk[$];
      chk("pc",    32'(pc),         32'(m_pc));
      chk("depth", 32'(depth),      32'(m_stk.size()));
      chk("top",   32'(topAddr),    32'(exp_top));
      chk("full",  32'(stackFull),  32'(m_stk.size() == DEPTH));
      chk("empty", 32'(stackEmpty), 32'(m_stk.size() == 0));
      chk("err",   32'(stackErr),   32'(m_err));
      $display("c%0d rst=%0d stall=%0d src=%0d push=%0d pop=%0d jmp=%h | pc=%h depth=%0d top=%h err=%0d",
               n_cyc, r, s, a, pu, po, jumpAddr, pc, depth, topAddr, stackErr);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; addrSrc = 2'd0; push = 1'b0; pop = 1'b0; jumpAddr = '0;

      // Reset and sequential fetch
      cyc(1, 0, 0, 0, 0, 0);
      chk("rst_pc", 32'(pc), 32'h0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0);
      chk("seq_pc", 32'(pc), 32'h5);

      // Single call/return
      cyc(0, 0, 3, 0, 0, 'h010);
      cyc(0, 0, 3, 1, 0, 'h200);
      chk("call_pc", 32'(pc), 32'h200);
      chk("call_top", 32'(topAddr), 32'h011);
      cyc(0, 0, 1, 0, 1, 0);
      chk("ret_pc", 32'(pc), 32'h011);

      // Fill, overflow, unwind
      cyc(0, 0, 3, 0, 0, 'h100);
      for (int i = 0; i < DEPTH; i++) cyc(0, 0, 3, 1, 0, 'h101 + i);
      chk("fill_full", 32'(stackFull), 32'h1);
      cyc(0, 0, 3, 1, 0, 'h300);
      chk("ovf_err", 32'(stackErr), 32'h1);
      chk("ovf_pc", 32'(pc), 32'h300);
      for (int i = 0; i < DEPTH; i++) begin
         cyc(0, 0, 1, 0, 1, 0);
         chk("lifo_pc", 32'(pc), 32'(32'h108 - i));
      end

      // Underflow
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 3, 0, 0, 'h020);
      cyc(0, 0, 1, 0, 1, 0);
      chk("unf_pc", 32'(pc), 32'h021);
      chk("unf_err", 32'(stackErr), 32'h1);

      // Address wrap
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 3, 0, 0, 'hFFF);
      cyc(0, 0, 0, 0, 0, 0);
      chk("wrap_pc", 32'(pc), 32'h0);
      cyc(0, 0, 3, 0, 0, 'hFFF);
      cyc(0, 0, 3, 1, 0, 'h400);
      chk("wrap_push", 32'(topAddr), 32'h0);
      chk("wrap_depth", 32'(depth), 32'h1);

      // Stall freezes a call, then reset with stall high overrides everything
      for (int i = 0; i < 3; i++) cyc(0, 1, 3, 1, 0, 'h555);
      chk("stall_pc", 32'(pc), 32'h400);
      cyc(0, 0, 3, 1, 0, 'h500);
      cyc(0, 0, 3, 1, 0, 'h600);
      cyc(0, 0, 0, 1, 1, 0);
      chk("pre_rst_depth", 32'(depth), 32'h3);
      cyc(1, 1, 3, 1, 0, 'h777);
      chk("rst_depth", 32'(depth), 32'h0);
      chk("rst_err", 32'(stackErr), 32'h0);

      // Randomized traffic
      for (int i = 0; i < 500; i++) begin
         bit        r, s, pu, po;
         bit [1:0]  a;
         int        sel;
         r   = ($urandom_range(0, 99) < 2);
         s   = ($urandom_range(0, 99) < 10);
         a   = 2'($urandom_range(0, 3));
         sel = $urandom_range(0, 9);
         pu  = (sel < 4) || (sel == 9);
         po  = (sel >= 4 && sel < 8) || (sel == 9);
         cyc(r, s, a, pu, po, int'($urandom_range(0, AMOD - 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Program-counter and return-address stack stage that sits directly downstream of the branch-control decoder in the processor front end. Each cycle it consumes the decoder's next-address select (`addrSrc`) and `push`/`pop` strobes plus the instruction's jump target, and produces the registered program counter for instruction fetch. It holds a bounded LIFO of return addresses for call/return and reports stack occupancy and misuse.

## Interface
Parameters:
- `ADDR_W`, 12: width of program counter, jump target and stack entries.
- `DEPTH`, 8: number of return-address entries; power of two, at least 2.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  when high, the cycle is frozen: no PC, stack or flag change.
- `addrSrc`  in  2  next-PC select: 00 = PC+1, 01 = top of stack (return), 10 = conditional-branch target, 11 = unconditional jump/call target.
- `push`  in  1  store return address (PC+1) on stack; accompanies a call.
- `pop`  in  1  remove top entry; accompanies a return.
- `jumpAddr`  in  ADDR_W  target address from the current instruction.
- `pc`  out  ADDR_W  registered program counter.
- `topAddr`  out  ADDR_W  combinational copy of the top stack entry; 0 when empty.
- `depth`  out  log2(DEPTH)+1  current number of valid entries.
- `stackFull`  out  1  `depth == DEPTH`.
- `stackEmpty`  out  1  `depth == 0`.
- `stackErr`  out  1  sticky error flag; cleared only by `rst`.

## Operation
- Reset: `pc`=0, `depth`=0, `stackErr`=0, `stackEmpty`=1, `stackFull`=0, `topAddr`=0; stack RAM contents are don't-care.
- Next PC (when `stall`=0): 00 → `pc+1`; 10/11 → `jumpAddr`; 01 → top entry when not empty.
- All PC arithmetic is modulo 2^ADDR_W: `pc` = all-ones with 00 wraps to 0.
- Push, not full: entry[`depth`] ← `pc+1` (mod 2^ADDR_W), `depth` +1. The PC still follows `addrSrc`.
- Push when full: entry discarded, `depth` unchanged, `stackErr` set; PC still follows `addrSrc`. Existing entries are untouched.
- Pop, not empty: `depth` −1; with `addrSrc`=01 the PC loads the entry being removed.
- Pop when empty: `depth` stays 0, `stackErr` set, and `addrSrc`=01 resolves to `pc+1`.
- `addrSrc`=01 without `pop`: PC loads the top entry (peek) and `depth` is unchanged. If the stack is empty, PC loads `pc+1` and `stackErr` is set.
- `push` and `pop` both high: stack unchanged, `stackErr` set, PC follows `addrSrc` (01 peeks as above).
- `stall`=1: all strobes are ignored and all registers hold, including the error flag.
- `stackFull`, `stackEmpty` and `topAddr` are decoded from registered `depth` and the stack entries.

## Timing
- Single-cycle stage. Inputs sampled at edge N; `pc`, `depth` and flags reflect them after edge N.
- `topAddr` changes in the same cycle as `depth`, with no extra latency.
- A return in cycle N+1 sees an address pushed in cycle N. No forwarding hazard exists because push and pop are never both honoured in one cycle.
- `rst` takes priority over `stall` and all other inputs. If it is asserted mid-sequence, the stack is empty after that edge and `pc`=0.
- `stackErr` rises on the edge following the offending cycle and stays high until `rst`.

## Test plan
- Reset then 5 cycles of `addrSrc`=00 → `pc` 0,1,2,3,4,5; `stackEmpty`=1; `stackErr`=0.
- At `pc`=0x010, call: `addrSrc`=11, `push`, `jumpAddr`=0x200 → `pc`=0x200, `depth`=1, `topAddr`=0x011. Then return (`addrSrc`=01, `pop`) → `pc`=0x011, `depth`=0.
- 8 nested calls from PCs 0x100–0x107 → `stackFull`=1. A 9th call → `stackErr`=1, `depth`=8, jump taken. Then 8 returns → `pc` 0x108 down to 0x101, in LIFO order.
- Return on empty stack at `pc`=0x020 → `pc`=0x021, `stackErr`=1, `depth`=0.
- Setup: `pc`=0xFFF with `ADDR_W`=12. Case a, `addrSrc`=00 → `pc`=0x000. Case b, call (`addrSrc`=11, `push`) → pushed entry 0x000.
- `stall` held 3 cycles during a call request → `pc` and `depth` are frozen. Assert `rst` with `depth`=3 → next cycle `pc`=0, `depth`=0, `stackErr`=0.
